// File: rtl/scan_host_seq_if.sv
// Host-side bundle between the scan sequencer, the AES blocks and the chip TAP pins.
// The slave modport is the sequencer; the master modport is whatever drives it.
interface scan_host_seq_if;
    logic         start;
    logic [127:0] ct_a;
    logic [127:0] ct_b;
    logic         tdo;
    logic         tms;
    logic         tdi;
    logic         busy;
    logic         done;
    logic [127:0] result;

    modport master (
        output start, ct_a, ct_b, tdo,
        input  tms, tdi, busy, done, result
    );

    modport slave (
        input  start, ct_a, ct_b, tdo,
        output tms, tdi, busy, done, result
    );
endinterface

// File: rtl/scan_host_seq.sv
// Host-side TAP sequencer: walks the nine-phase secure-scan flow, one (tms, tdi) pair per cycle.
// State (r_state, r_phase, r_cnt) always names the stream element currently on the pins.
module scan_host_seq #(
    parameter int DEC_WAIT = 12,
    parameter int CAP_WAIT = 2,
    parameter int ENC_WAIT = 11
) (
    input  logic           clk,
    input  logic           trst,
    scan_host_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_TAIL  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]   r_state;
    logic [3:0]   r_phase;
    logic [7:0]   r_cnt;
    logic         r_tms;
    logic         r_tdi;
    logic         r_busy;
    logic         r_done;
    logic [127:0] r_result;
    logic [127:0] r_ct_a;
    logic [127:0] r_ct_b;

    logic [2:0]   w_nstate;
    logic [3:0]   w_nphase;
    logic [7:0]   w_ncnt;
    logic         w_adv;
    logic         w_accept;
    logic         w_tms;
    logic         w_tdi;

    // Preamble tms bits, first bit in the LSB.
    function automatic logic [3:0] pre_pat(input logic [3:0] ph);
        case (ph)
            4'd1, 4'd3: return 4'b0011;
            4'd2, 4'd4: return 4'b0001;
            4'd5, 4'd7: return 4'b0110;
            4'd6:       return 4'b0101;
            4'd8:       return 4'b1001;
            4'd9:       return 4'b1110;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [7:0] pre_len(input logic [3:0] ph);
        case (ph)
            4'd1, 4'd3:                   return 8'd2;
            4'd5, 4'd6, 4'd7:             return 8'd3;
            4'd2, 4'd4, 4'd8, 4'd9:       return 8'd4;
            default:                      return 8'd1;
        endcase
    endfunction

    function automatic logic [7:0] wait_len(input logic [3:0] ph);
        case (ph)
            4'd2, 4'd4: return 8'(DEC_WAIT);
            4'd6:       return 8'(CAP_WAIT);
            4'd8:       return 8'(ENC_WAIT);
            default:    return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] tail_len(input logic [3:0] ph);
        case (ph)
            4'd2, 4'd4: return 8'd4;
            4'd8:       return 8'd1;
            default:    return 8'd0;
        endcase
    endfunction

    always_comb begin
        w_nstate = r_state;
        w_nphase = r_phase;
        w_ncnt   = r_cnt;
        w_adv    = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_nstate = S_PRE;
                    w_nphase = 4'd1;
                    w_ncnt   = 8'd0;
                end
            end
            S_PRE: begin
                if (r_cnt != pre_len(r_phase) - 8'd1) begin
                    w_ncnt = r_cnt + 8'd1;
                end else if (r_phase[0]) begin
                    w_nstate = S_SHIFT;
                    w_ncnt   = 8'd0;
                end else if (wait_len(r_phase) != 8'd0) begin
                    w_nstate = S_HOLD;
                    w_ncnt   = 8'd0;
                end else if (tail_len(r_phase) != 8'd0) begin
                    w_nstate = S_TAIL;
                    w_ncnt   = 8'd0;
                end else begin
                    w_adv = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt != 8'd127) w_ncnt = r_cnt + 8'd1;
                else                 w_adv  = 1'b1;
            end
            S_HOLD: begin
                if (r_cnt != wait_len(r_phase) - 8'd1) begin
                    w_ncnt = r_cnt + 8'd1;
                end else if (tail_len(r_phase) != 8'd0) begin
                    w_nstate = S_TAIL;
                    w_ncnt   = 8'd0;
                end else begin
                    w_adv = 1'b1;
                end
            end
            S_TAIL: begin
                if (r_cnt != tail_len(r_phase) - 8'd1) w_ncnt = r_cnt + 8'd1;
                else                                   w_adv  = 1'b1;
            end
            default: w_nstate = S_IDLE;
        endcase

        if (w_adv) begin
            w_ncnt = 8'd0;
            if (r_phase == 4'd9) begin
                w_nstate = S_DONE;
            end else begin
                w_nstate = S_PRE;
                w_nphase = r_phase + 4'd1;
            end
        end
    end

    // Pin values for the element that the next state describes.
    always_comb begin
        w_tms = 1'b0;
        w_tdi = 1'b0;
        case (w_nstate)
            S_PRE:   w_tms = pre_pat(w_nphase)[w_ncnt[1:0]];
            S_SHIFT: begin
                w_tms = (w_ncnt != 8'd127);
                if (w_nphase == 4'd1)      w_tdi = r_ct_a[w_ncnt[6:0]];
                else if (w_nphase == 4'd3) w_tdi = r_ct_b[w_ncnt[6:0]];
            end
            S_HOLD:  w_tms = 1'b1;
            default: w_tms = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!trst) begin
            r_state  <= S_IDLE;
            r_phase  <= 4'd0;
            r_cnt    <= 8'd0;
            r_tms    <= 1'b0;
            r_tdi    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_nstate;
            r_phase <= w_nphase;
            r_cnt   <= w_ncnt;
            r_tms   <= w_tms;
            r_tdi   <= w_tdi;
            r_busy  <= (w_nstate != S_IDLE) && (w_nstate != S_DONE);
            r_done  <= (w_nstate == S_DONE);
            // The element on the pins ends at this edge, so tdo now belongs to bit r_cnt.
            if (w_accept)
                r_result <= '0;
            else if (r_state == S_SHIFT && r_phase == 4'd9)
                r_result[r_cnt[6:0]] <= bus.tdo;
        end
    end

    always_ff @(posedge clk) begin
        if (trst && w_accept) begin
            r_ct_a <= bus.ct_a;
            r_ct_b <= bus.ct_b;
        end
    end

    assign bus.tms    = r_tms;
    assign bus.tdi    = r_tdi;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_scan_host_seq.sv
// Bench for scan_host_seq: expected pin stream built from the phase table, tdo stub replays a pattern.
module tb_scan_host_seq;
    logic clk = 1'b0;
    logic trst;
    always #5 clk = ~clk;

    scan_host_seq_if bus ();
    scan_host_seq_if bus0 ();

    assign bus0.start = bus.start;
    assign bus0.ct_a  = bus.ct_a;
    assign bus0.ct_b  = bus.ct_b;
    assign bus0.tdo   = bus.tdo;

    scan_host_seq #(.DEC_WAIT(12), .CAP_WAIT(2), .ENC_WAIT(11)) u_dut (
        .clk  (clk),
        .trst (trst),
        .bus  (bus.slave)
    );

    scan_host_seq #(.DEC_WAIT(0), .CAP_WAIT(0), .ENC_WAIT(0)) u_var (
        .clk  (clk),
        .trst (trst),
        .bus  (bus0.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] exp_q[$];
    logic [1:0] exp0_q[$];
    logic       tdo_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stream as {tms,tdi} per cycle, plus the tdo value to present during each cycle.
    task automatic build(input logic [127:0] a, input logic [127:0] b, input logic [127:0] pat,
                         input int dw, input int cw, input int ew);
        string pre;
        int    hold;
        int    tail;
        exp_q.delete();
        tdo_q.delete();
        for (int ph = 1; ph <= 9; ph++) begin
            case (ph)
                1, 3:    pre = "11";
                2, 4:    pre = "1000";
                5, 7:    pre = "011";
                6:       pre = "101";
                8:       pre = "1001";
                default: pre = "0111";
            endcase
            hold = (ph == 2 || ph == 4) ? dw : (ph == 6) ? cw : (ph == 8) ? ew : 0;
            tail = (ph == 2 || ph == 4) ? 4 : (ph == 8) ? 1 : 0;
            for (int j = 0; j < pre.len(); j++) begin
                exp_q.push_back({pre[j] == 8'h31, 1'b0});
                tdo_q.push_back(1'b0);
            end
            if (ph % 2 == 1) begin
                for (int i = 0; i < 128; i++) begin
                    exp_q.push_back({i != 127, (ph == 1) ? a[i] : (ph == 3) ? b[i] : 1'b0});
                    tdo_q.push_back((ph == 9) ? pat[i] : 1'b0);
                end
            end
            for (int j = 0; j < hold; j++) begin
                exp_q.push_back(2'b10);
                tdo_q.push_back(1'b0);
            end
            for (int j = 0; j < tail; j++) begin
                exp_q.push_back(2'b00);
                tdo_q.push_back(1'b0);
            end
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run(input logic [127:0] a, input logic [127:0] b, input logic [127:0] pat,
                       input int pulse_at, input int abort_at, input bit btb);
        int n;
        int k0;
        build(a, b, pat, 0, 0, 0);
        exp0_q = exp_q;
        build(a, b, pat, 12, 2, 11);
        n  = exp_q.size();
        k0 = -1;
        bus.ct_a  = a;
        bus.ct_b  = b;
        bus.start = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                bus.start = 1'b0;
                bus.ct_a  = ~a;
                bus.ct_b  = ~b;
                chk("accept_result_clear", bus.result, 128'd0);
            end
            if (k == abort_at) begin
                chk("abort_pins", 128'({bus.tms, bus.tdi, bus.busy, bus.done}), 128'd0);
                chk("abort_result", bus.result, 128'd0);
                trst = 1'b1;
                return;
            end
            chk("stream", 128'({bus.tms, bus.tdi}), 128'(exp_q[k]));
            chk("busy_done", 128'({bus.busy, bus.done}), 128'(2'b10));
            if (k < exp0_q.size())
                chk("var_stream", 128'({bus0.tms, bus0.tdi}), 128'(exp0_q[k]));
            if (bus0.done && k0 < 0) k0 = k;
            bus.tdo = tdo_q[k];
            if (k == pulse_at - 1) begin
                bus.start = 1'b1;
                bus.ct_a  = rnd128();
                bus.ct_b  = rnd128();
            end
            if (k == pulse_at) bus.start = 1'b0;
            if (k == abort_at - 1) trst = 1'b0;
            if (btb && k == n - 1) bus.start = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.tdo = 1'b0;
        chk("end_pins", 128'({bus.done, bus.busy, bus.tms, bus.tdi}), 128'(4'b1000));
        chk("result", bus.result, pat);
        chk("var_done_cycle", 128'(k0), 128'(678));
        if (btb) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            chk("btb_accept", 128'({bus.done, bus.busy, bus.tms}), 128'(3'b011));
            chk("btb_result_clear", bus.result, 128'd0);
            trst = 1'b0;
            @(posedge clk);
            #1;
            trst = 1'b1;
            chk("btb_reset", 128'({bus.tms, bus.tdi, bus.busy, bus.done}), 128'd0);
        end
    endtask

    initial begin
        logic [127:0] pat_a5;
        pat_a5    = {16{8'hA5}};
        trst      = 1'b0;
        bus.start = 1'b1;
        bus.ct_a  = rnd128();
        bus.ct_b  = rnd128();
        bus.tdo   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pins", 128'({bus.tms, bus.tdi, bus.busy, bus.done}), 128'd0);
        chk("reset_result", bus.result, 128'd0);
        chk("reset_var_pins", 128'({bus0.tms, bus0.tdi, bus0.busy, bus0.done}), 128'd0);
        bus.start = 1'b0;
        bus.tdo   = 1'b0;
        trst      = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_pins", 128'({bus.tms, bus.tdi, bus.busy, bus.done}), 128'd0);

        run(128'd1, rnd128(), pat_a5, -1, -1, 1'b0);
        run(rnd128(), rnd128(), rnd128(), 50, -1, 1'b0);
        run(rnd128(), rnd128(), rnd128(), -1, 300, 1'b0);
        run(rnd128(), rnd128(), rnd128(), -1, -1, 1'b0);
        run(rnd128(), rnd128(), rnd128(), -1, 650, 1'b0);
        run(rnd128(), rnd128(), rnd128(), -1, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scan_host_seq.md
# scan_host_seq

Host-side TAP sequencer for the secure-scan adder chip. It drives `tms`/`tdi` and samples `tdo` through the full nine-phase flow that the bench currently scripts by hand:
- shift encrypted A, decrypt A;
- shift encrypted B, decrypt B;
- move, capture the sum, forward it, encrypt it;
- shift the encrypted result out.

It sits between the host-side AES blocks (which supply the two ciphertexts and later decrypt the result) and the chip's `tdi`/`tms`/`tdo` pins.

## Interface
- `DEC_WAIT`, 12: cycles `tms` is held 1 while the chip decrypts an operand.
- `CAP_WAIT`, 2: cycles `tms` is held 1 after the capture preamble.
- `ENC_WAIT`, 11: cycles `tms` is held 1 while the chip encrypts the result.
- `clk` in 1: single clock; all state updates on the rising edge.
- `trst` in 1: reset, synchronous, active-low.
- `start` in 1: begin a sequence; accepted only when `busy`=0.
- `ct_a` in 128: encrypted operand A; latched on the accepting edge.
- `ct_b` in 128: encrypted operand B; latched on the accepting edge.
- `tdo` in 1: chip scan output.
- `tms` out 1: chip mode select; registered.
- `tdi` out 1: chip scan input; registered.
- `busy` out 1: high from the accepting edge until `done` rises.
- `done` out 1: high from sequence end until the next accepted `start`.
- `result` out 128: encrypted result collected from `tdo`.

## Operation
- Top FSM:
  - IDLE -> PRE on `start`.
  - PRE -> SHIFT or HOLD, per phase.
  - SHIFT -> next phase.
  - HOLD -> TAIL or next phase.
  - TAIL -> next phase.
  - After phase 9 -> DONE. DONE -> PRE on `start`.
- A 4-bit phase index and a bit/cycle counter drive the FSM. The counter is 8 bits, sized for max(128, parameters); parameters must be ≤255.
- Each cycle emits exactly one (`tms`, `tdi`) pair.
- `tdi`=0 outside SHIFT, and in every SHIFT except phases 1 and 3.
- Phases, with the preamble `tms` bits in order:
  1. SHIFT_A: preamble 1,1; then shift 128 bits, `tdi`=`ct_a[i]` for i=0..127 (LSB first).
  2. DEC_A: preamble 1,0,0,0; HOLD `tms`=1 for `DEC_WAIT` cycles; TAIL `tms`=0 for 4 cycles.
  3. SHIFT_B: as phase 1, using `ct_b`.
  4. DEC_B: as phase 2.
  5. MOVE: preamble 0,1,1; shift 128 zeros.
  6. CAPTURE: preamble 1,0,1; HOLD `tms`=1 for `CAP_WAIT` cycles.
  7. FWD: preamble 0,1,1; shift 128 zeros.
  8. ENC: preamble 1,0,0,1; HOLD `tms`=1 for `ENC_WAIT` cycles; TAIL `tms`=0 for 1 cycle.
  9. OUT: preamble 0,1,1,1; shift 128 zeros; sample `tdo` into `result[i]`.
- SHIFT `tms` rule: `tms`=1 for bits 0..126 and 0 on bit 127 (this exits shift on the last bit).
- The `result` register is cleared on accept and fills only during phase 9.
- `start` while `busy`=1 is ignored; the latched operands are unchanged.
- `start` in the same cycle that `done` rises is not accepted. It is accepted on the following edge if still high.

## Timing
- Reset (`trst`=0 at an edge): `tms`=0, `tdi`=0, `busy`=0, `done`=0, `result`=0, FSM=IDLE, counters=0.
- Reset mid-sequence aborts immediately: the same values apply at that edge and no partial `result` survives.
- Accepting edge E0:
  - `busy`=1 and `done`=0;
  - `tms`=1 (phase 1, preamble bit 1) is driven from E0.
- Output timing:
  - Bit n of the stream occupies E(n-1)..E(n).
  - The chip samples it at E(n).
  - `result[i]` takes the `tdo` value present at the edge ending shift bit i of phase 9.
- Phase lengths in cycles:
  - phases 1, 3: 130;
  - phases 2, 4: 8+`DEC_WAIT`;
  - phases 5, 7: 131;
  - phase 6: 3+`CAP_WAIT`;
  - phase 8: 5+`ENC_WAIT`;
  - phase 9: 132.
- Total = 678 + 2·`DEC_WAIT` + `CAP_WAIT` + `ENC_WAIT`, which is 715 with defaults.
- At E0+total: `done`=1, `busy`=0, `tms`=0, `tdi`=0, and `result` is stable.
- Zero-valued wait parameters remove that HOLD entirely; there is no extra cycle.
- There is no combinational path from `tdo` or `start` to any output.

## Test plan
- Reset: hold `trst`=0 for 3 edges with `start`=1 -> `tms`=`tdi`=`busy`=`done`=0 and `result`=0.
- Phase 1 stream: `ct_a`=128'h1 -> over E0..E130, `tms`=1,1 then 127×1 then 0. `tdi`=0,0,1, then 127 zeros.
- Full run with defaults and a `tdo` stub driving 128'hA5A5…A5 LSB-first during phase 9 -> `done` at E0+715 and `result`=128'hA5A5…A5.
- Parameter variant: `DEC_WAIT`=0, `CAP_WAIT`=0, `ENC_WAIT`=0 -> `done` at E0+678.
- `start` pulsed at E0+50 while busy -> ignored; `done` is still at E0+715.
- Abort: `trst`=0 at E0+300 -> all outputs reset at that edge. A new `start` then completes 715 cycles later with the correct `result`.
